// File: rtl/reg_file_rename_pkg.sv
// rtl/reg_file_rename_pkg.sv - shared widths and ROB tag range for the renaming register file.
// Optional CDB forwarding is selected with REGFILE_CDB_FWD_EN.
package reg_file_rename_pkg;
    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;
    localparam int ROB_SIZE  = 16;
    localparam int ROB_TAG_W = $clog2(ROB_SIZE);
    localparam int REG_IDX_W = 5;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
endpackage

// File: rtl/reg_file_rename_if.sv
// rtl/reg_file_rename_if.sv - issue/commit/read bundle between decode, ROB and the register file.
// CDB broadcast signals exist only when REGFILE_CDB_FWD_EN is defined.
interface reg_file_rename_if
#(
    parameter int DATA_W = reg_file_rename_pkg::XLEN,
    parameter int TAG_W  = reg_file_rename_pkg::ROB_TAG_W
);
    import reg_file_rename_pkg::*;

    logic                 rdy;
    logic                 rollback;
    logic                 issue_valid;
    logic [REG_IDX_W-1:0] issue_rd;
    logic [TAG_W-1:0]     issue_tag;
    logic                 commit_valid;
    logic [REG_IDX_W-1:0] commit_rd;
    logic [TAG_W-1:0]     commit_rdTag;
    logic [DATA_W-1:0]    commit_rdVal;
    logic [REG_IDX_W-1:0] rs1_idx;
    logic [REG_IDX_W-1:0] rs2_idx;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic [DATA_W-1:0]    rs1_val;
    logic [DATA_W-1:0]    rs2_val;
    logic [TAG_W-1:0]     rs1_tag;
    logic [TAG_W-1:0]     rs2_tag;
`ifdef REGFILE_CDB_FWD_EN
    logic                 B_ALU_valid;
    logic [DATA_W-1:0]    B_ALU_result;
    logic [TAG_W-1:0]     B_ALU_rdTag;
    logic                 B_LSB_valid;
    logic [DATA_W-1:0]    B_LSB_result;
    logic [TAG_W-1:0]     B_LSB_rdTag;
`endif

    modport master (
        output rdy, rollback, issue_valid, issue_rd, issue_tag,
        output commit_valid, commit_rd, commit_rdTag, commit_rdVal,
        output rs1_idx, rs2_idx,
`ifdef REGFILE_CDB_FWD_EN
        output B_ALU_valid, B_ALU_result, B_ALU_rdTag,
        output B_LSB_valid, B_LSB_result, B_LSB_rdTag,
`endif
        input  rs1_busy, rs2_busy, rs1_val, rs2_val, rs1_tag, rs2_tag
    );

    modport slave (
        input  rdy, rollback, issue_valid, issue_rd, issue_tag,
        input  commit_valid, commit_rd, commit_rdTag, commit_rdVal,
        input  rs1_idx, rs2_idx,
`ifdef REGFILE_CDB_FWD_EN
        input  B_ALU_valid, B_ALU_result, B_ALU_rdTag,
        input  B_LSB_valid, B_LSB_result, B_LSB_rdTag,
`endif
        output rs1_busy, rs2_busy, rs1_val, rs2_val, rs1_tag, rs2_tag
    );
endinterface

// File: rtl/reg_file_rename_reg_read_port.sv
// rtl/reg_file_rename_reg_read_port.sv - combinational source operand lookup with commit bypass.
// With REGFILE_CDB_FWD_EN defined, ALU then LSB broadcasts also forward into a busy source.
module reg_file_rename_reg_read_port
    import reg_file_rename_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ROB_TAG_W = 4
)(
    input  logic [REG_IDX_W-1:0] i_idx,
    input  logic                 i_reg_busy,
    input  logic [ROB_TAG_W-1:0] i_reg_tag,
    input  logic [XLEN-1:0]      i_reg_val,
    input  logic                 i_commit_valid,
    input  logic [REG_IDX_W-1:0] i_commit_rd,
    input  logic [ROB_TAG_W-1:0] i_commit_tag,
    input  logic [XLEN-1:0]      i_commit_val,
`ifdef REGFILE_CDB_FWD_EN
    input  logic                 i_alu_valid,
    input  logic [XLEN-1:0]      i_alu_result,
    input  logic [ROB_TAG_W-1:0] i_alu_tag,
    input  logic                 i_lsb_valid,
    input  logic [XLEN-1:0]      i_lsb_result,
    input  logic [ROB_TAG_W-1:0] i_lsb_tag,
`endif
    output logic                 o_busy,
    output logic [XLEN-1:0]      o_val,
    output logic [ROB_TAG_W-1:0] o_tag
);
    logic w_commit_hit;

    // The ROB drops the retiring entry this cycle, so its value must come from the commit port.
    assign w_commit_hit = i_commit_valid && (i_commit_rd == i_idx) &&
                          i_reg_busy && (i_reg_tag == i_commit_tag);

    always_comb begin
        o_busy = i_reg_busy;
        o_val  = i_reg_val;
        o_tag  = i_reg_tag;
        if (i_idx == '0) begin
            o_busy = FALSE;
            o_val  = '0;
            o_tag  = '0;
        end else if (w_commit_hit) begin
            o_busy = FALSE;
            o_val  = i_commit_val;
`ifdef REGFILE_CDB_FWD_EN
        end else if (i_reg_busy && i_alu_valid && (i_alu_tag == i_reg_tag)) begin
            o_busy = FALSE;
            o_val  = i_alu_result;
        end else if (i_reg_busy && i_lsb_valid && (i_lsb_tag == i_reg_tag)) begin
            o_busy = FALSE;
            o_val  = i_lsb_result;
`endif
        end
    end
endmodule

// File: rtl/reg_file_rename.sv
// rtl/reg_file_rename.sv - architectural register file holding busy bit and producer ROB tag per register.
// REGFILE_CDB_FWD_EN adds CDB forwarding on the read ports; stored state is written only by commit.
module reg_file_rename
    import reg_file_rename_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int ROB_TAG_W = 4
)(
    input  logic                  clk,
    input  logic                  rst,
    reg_file_rename_if.slave      bus
);
    logic [XLEN-1:0]      r_val [NUM_REGS];
    logic [ROB_TAG_W-1:0] r_tag [NUM_REGS];
    logic [NUM_REGS-1:0]  r_busy;

    logic w_commit_en;
    logic w_issue_en;
    logic w_rollback_en;

    assign w_commit_en   = bus.commit_valid && bus.rdy && (bus.commit_rd != '0);
    assign w_rollback_en = bus.rollback && bus.rdy;
    // An issue racing a rollback belongs to the squashed path and is dropped.
    assign w_issue_en    = bus.issue_valid && bus.rdy && (bus.issue_rd != '0) && !bus.rollback;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            // Later assignments win: commit, then issue, then rollback.
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_commit_en && (bus.commit_rd == REG_IDX_W'(i))) begin
                    r_val[i] <= bus.commit_rdVal;
                    if (r_busy[i] && (r_tag[i] == bus.commit_rdTag))
                        r_busy[i] <= 1'b0;
                end
                if (w_issue_en && (bus.issue_rd == REG_IDX_W'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= bus.issue_tag;
                end
                if (w_rollback_en)
                    r_busy[i] <= 1'b0;
            end
        end
    end

    reg_file_rename_reg_read_port #(.XLEN(XLEN), .ROB_TAG_W(ROB_TAG_W)) u_rs1 (
        .i_idx          (bus.rs1_idx),
        .i_reg_busy     (r_busy[bus.rs1_idx]),
        .i_reg_tag      (r_tag[bus.rs1_idx]),
        .i_reg_val      (r_val[bus.rs1_idx]),
        .i_commit_valid (bus.commit_valid),
        .i_commit_rd    (bus.commit_rd),
        .i_commit_tag   (bus.commit_rdTag),
        .i_commit_val   (bus.commit_rdVal),
`ifdef REGFILE_CDB_FWD_EN
        .i_alu_valid    (bus.B_ALU_valid),
        .i_alu_result   (bus.B_ALU_result),
        .i_alu_tag      (bus.B_ALU_rdTag),
        .i_lsb_valid    (bus.B_LSB_valid),
        .i_lsb_result   (bus.B_LSB_result),
        .i_lsb_tag      (bus.B_LSB_rdTag),
`endif
        .o_busy         (bus.rs1_busy),
        .o_val          (bus.rs1_val),
        .o_tag          (bus.rs1_tag)
    );

    reg_file_rename_reg_read_port #(.XLEN(XLEN), .ROB_TAG_W(ROB_TAG_W)) u_rs2 (
        .i_idx          (bus.rs2_idx),
        .i_reg_busy     (r_busy[bus.rs2_idx]),
        .i_reg_tag      (r_tag[bus.rs2_idx]),
        .i_reg_val      (r_val[bus.rs2_idx]),
        .i_commit_valid (bus.commit_valid),
        .i_commit_rd    (bus.commit_rd),
        .i_commit_tag   (bus.commit_rdTag),
        .i_commit_val   (bus.commit_rdVal),
`ifdef REGFILE_CDB_FWD_EN
        .i_alu_valid    (bus.B_ALU_valid),
        .i_alu_result   (bus.B_ALU_result),
        .i_alu_tag      (bus.B_ALU_rdTag),
        .i_lsb_valid    (bus.B_LSB_valid),
        .i_lsb_result   (bus.B_LSB_result),
        .i_lsb_tag      (bus.B_LSB_rdTag),
`endif
        .o_busy         (bus.rs2_busy),
        .o_val          (bus.rs2_val),
        .o_tag          (bus.rs2_tag)
    );
endmodule

// File: tb/tb_reg_file_rename.sv
// tb/tb_reg_file_rename.sv - directed and randomized checks of reg_file_rename against a reference model.
// CDB forwarding checks are compiled in when REGFILE_CDB_FWD_EN is defined.
module tb_reg_file_rename;
    import reg_file_rename_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_rename_if bus ();

    reg_file_rename dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0]      m_val  [32];
    logic                 m_busy [32];
    logic [ROB_TAG_W-1:0] m_tag  [32];

    task automatic idle();
        bus.rdy          = 1'b1;
        bus.rollback     = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.issue_rd     = '0;
        bus.issue_tag    = '0;
        bus.commit_valid = 1'b0;
        bus.commit_rd    = '0;
        bus.commit_rdTag = '0;
        bus.commit_rdVal = '0;
        bus.rs1_idx      = '0;
        bus.rs2_idx      = '0;
`ifdef REGFILE_CDB_FWD_EN
        bus.B_ALU_valid  = 1'b0;
        bus.B_ALU_result = '0;
        bus.B_ALU_rdTag  = '0;
        bus.B_LSB_valid  = 1'b0;
        bus.B_LSB_result = '0;
        bus.B_LSB_rdTag  = '0;
`endif
    endtask

    // Next architectural state from the rules: commit writes, rollback wins over issue.
    function automatic void model_step();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end else if (bus.rdy) begin
            if (bus.commit_valid && bus.commit_rd != 0) begin
                m_val[bus.commit_rd] = bus.commit_rdVal;
                if (m_busy[bus.commit_rd] && m_tag[bus.commit_rd] == bus.commit_rdTag)
                    m_busy[bus.commit_rd] = 1'b0;
            end
            if (bus.rollback) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (bus.issue_valid && bus.issue_rd != 0) begin
                m_busy[bus.issue_rd] = 1'b1;
                m_tag[bus.issue_rd]  = bus.issue_tag;
            end
        end
    endfunction

    function automatic void model_read(input logic [4:0] idx, output logic eb,
                                       output logic [XLEN-1:0] ev, output logic [ROB_TAG_W-1:0] et);
        eb = m_busy[idx]; ev = m_val[idx]; et = m_tag[idx];
        if (idx == 0) begin
            eb = 1'b0; ev = '0; et = '0;
        end else if (m_busy[idx] && bus.commit_valid && bus.commit_rd == idx && m_tag[idx] == bus.commit_rdTag) begin
            eb = 1'b0; ev = bus.commit_rdVal;
`ifdef REGFILE_CDB_FWD_EN
        end else if (m_busy[idx] && bus.B_ALU_valid && bus.B_ALU_rdTag == m_tag[idx]) begin
            eb = 1'b0; ev = bus.B_ALU_result;
        end else if (m_busy[idx] && bus.B_LSB_valid && bus.B_LSB_rdTag == m_tag[idx]) begin
            eb = 1'b0; ev = bus.B_LSB_result;
`endif
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        tick(); tick();
        rst = 1'b0;
        bus.rs1_idx = 5'd5;
        #2;
        total++; if (bus.rs1_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", bus.rs1_busy); end
        total++; if (bus.rs1_val !== 32'h0) begin bad++; $display("FAIL reset_val got=%h exp=0", bus.rs1_val); end
        total++; if (bus.rs1_tag !== 4'h0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", bus.rs1_tag); end
    endtask

    task automatic test_x0();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.issue_tag = 4'd3;
        tick(); idle();
        bus.rs1_idx = 5'd0;
        #2;
        total++; if (bus.rs1_busy !== 1'b0) begin bad++; $display("FAIL x0_busy got=%0d exp=0", bus.rs1_busy); end
        total++; if (bus.rs1_val !== 32'h0) begin bad++; $display("FAIL x0_val got=%h exp=0", bus.rs1_val); end
    endtask

    task automatic test_issue_commit();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.issue_tag = 4'd2;
        tick(); idle();
        bus.rs1_idx = 5'd5;
        #2;
        total++; if (bus.rs1_busy !== 1'b1) begin bad++; $display("FAIL issue_busy got=%0d exp=1", bus.rs1_busy); end
        total++; if (bus.rs1_tag !== 4'd2) begin bad++; $display("FAIL issue_tag got=%0d exp=2", bus.rs1_tag); end
        bus.commit_valid = 1'b1; bus.commit_rd = 5'd5; bus.commit_rdTag = 4'd2; bus.commit_rdVal = 32'h1234;
        #1;
        total++; if (bus.rs1_busy !== 1'b0) begin bad++; $display("FAIL bypass_busy got=%0d exp=0", bus.rs1_busy); end
        total++; if (bus.rs1_val !== 32'h1234) begin bad++; $display("FAIL bypass_val got=%h exp=1234", bus.rs1_val); end
        tick(); idle();
        bus.rs1_idx = 5'd5;
        #2;
        total++; if (bus.rs1_busy !== 1'b0) begin bad++; $display("FAIL commit_busy got=%0d exp=0", bus.rs1_busy); end
        total++; if (bus.rs1_val !== 32'h1234) begin bad++; $display("FAIL commit_val got=%h exp=1234", bus.rs1_val); end
    endtask

    task automatic test_stale_commit();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.issue_tag = 4'd1;
        tick();
        bus.issue_tag = 4'd4;
        tick(); idle();
        bus.commit_valid = 1'b1; bus.commit_rd = 5'd7; bus.commit_rdTag = 4'd1; bus.commit_rdVal = 32'hAA;
        bus.rs1_idx = 5'd7;
        #2;
        total++; if (bus.rs1_busy !== 1'b1) begin bad++; $display("FAIL stale_nobypass got=%0d exp=1", bus.rs1_busy); end
        tick(); idle();
        bus.rs1_idx = 5'd7;
        #2;
        total++; if (bus.rs1_busy !== 1'b1) begin bad++; $display("FAIL stale_busy got=%0d exp=1", bus.rs1_busy); end
        total++; if (bus.rs1_tag !== 4'd4) begin bad++; $display("FAIL stale_tag got=%0d exp=4", bus.rs1_tag); end
        total++; if (bus.rs1_val !== 32'hAA) begin bad++; $display("FAIL stale_val got=%h exp=aa", bus.rs1_val); end
        bus.commit_valid = 1'b1; bus.commit_rd = 5'd7; bus.commit_rdTag = 4'd4; bus.commit_rdVal = 32'hBB;
        tick(); idle();
        bus.rs1_idx = 5'd7;
        #2;
        total++; if (bus.rs1_busy !== 1'b0) begin bad++; $display("FAIL latest_busy got=%0d exp=0", bus.rs1_busy); end
        total++; if (bus.rs1_val !== 32'hBB) begin bad++; $display("FAIL latest_val got=%h exp=bb", bus.rs1_val); end
    endtask

    task automatic test_same_cycle();
        bus.commit_valid = 1'b1; bus.commit_rd = 5'd9; bus.commit_rdTag = 4'd3; bus.commit_rdVal = 32'h55;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.issue_tag = 4'd6;
        tick(); idle();
        bus.rs1_idx = 5'd9;
        #2;
        total++; if (bus.rs1_busy !== 1'b1) begin bad++; $display("FAIL same_busy got=%0d exp=1", bus.rs1_busy); end
        total++; if (bus.rs1_tag !== 4'd6) begin bad++; $display("FAIL same_tag got=%0d exp=6", bus.rs1_tag); end
        total++; if (bus.rs1_val !== 32'h55) begin bad++; $display("FAIL same_val got=%h exp=55", bus.rs1_val); end
    endtask

    task automatic test_rollback();
        for (int r = 1; r <= 3; r++) begin
            bus.commit_valid = 1'b1; bus.commit_rd = 5'(r); bus.commit_rdTag = 4'd0; bus.commit_rdVal = 32'(r * 32'h11);
            bus.issue_valid = 1'b1; bus.issue_rd = 5'(r); bus.issue_tag = 4'(r);
            tick();
        end
        idle();
        bus.rollback = 1'b1; bus.issue_valid = 1'b1; bus.issue_rd = 5'd4; bus.issue_tag = 4'd5;
        bus.rs1_idx = 5'd3;
        #2;
        total++; if (bus.rs1_busy !== 1'b1) begin bad++; $display("FAIL pre_rollback_busy got=%0d exp=1", bus.rs1_busy); end
        tick(); idle();
        bus.rs1_idx = 5'd1; bus.rs2_idx = 5'd2;
        #2;
        total++; if ({bus.rs1_busy, bus.rs2_busy} !== 2'b00) begin bad++; $display("FAIL rb_busy12 got=%b exp=00", {bus.rs1_busy, bus.rs2_busy}); end
        total++; if (bus.rs1_val !== 32'h11) begin bad++; $display("FAIL rb_val1 got=%h exp=11", bus.rs1_val); end
        total++; if (bus.rs2_val !== 32'h22) begin bad++; $display("FAIL rb_val2 got=%h exp=22", bus.rs2_val); end
        bus.rs1_idx = 5'd3; bus.rs2_idx = 5'd4;
        #1;
        total++; if ({bus.rs1_busy, bus.rs2_busy} !== 2'b00) begin bad++; $display("FAIL rb_busy34 got=%b exp=00", {bus.rs1_busy, bus.rs2_busy}); end
        total++; if (bus.rs1_val !== 32'h33) begin bad++; $display("FAIL rb_val3 got=%h exp=33", bus.rs1_val); end
    endtask

    task automatic test_rdy_low();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd10; bus.issue_tag = 4'd7;
        tick(); idle();
        bus.rdy = 1'b0;
        bus.commit_valid = 1'b1; bus.commit_rd = 5'd10; bus.commit_rdTag = 4'd7; bus.commit_rdVal = 32'h99;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd11; bus.issue_tag = 4'd2;
        tick(); idle();
        bus.rs1_idx = 5'd10; bus.rs2_idx = 5'd11;
        #2;
        total++; if (bus.rs1_busy !== 1'b1) begin bad++; $display("FAIL rdy_busy got=%0d exp=1", bus.rs1_busy); end
        total++; if (bus.rs1_tag !== 4'd7) begin bad++; $display("FAIL rdy_tag got=%0d exp=7", bus.rs1_tag); end
        total++; if (bus.rs1_val !== 32'h0) begin bad++; $display("FAIL rdy_val got=%h exp=0", bus.rs1_val); end
        total++; if (bus.rs2_busy !== 1'b0) begin bad++; $display("FAIL rdy_issue got=%0d exp=0", bus.rs2_busy); end
    endtask

    task automatic test_reset_no_rdy();
        rst = 1'b1; bus.rdy = 1'b0;
        tick();
        rst = 1'b0; idle();
        bus.rs1_idx = 5'd10; bus.rs2_idx = 5'd9;
        #2;
        total++; if (bus.rs1_busy !== 1'b0) begin bad++; $display("FAIL rst_rdy_busy got=%0d exp=0", bus.rs1_busy); end
        total++; if (bus.rs1_tag !== 4'd0) begin bad++; $display("FAIL rst_rdy_tag got=%0d exp=0", bus.rs1_tag); end
        total++; if (bus.rs2_val !== 32'h0) begin bad++; $display("FAIL rst_rdy_val got=%h exp=0", bus.rs2_val); end
    endtask

`ifdef REGFILE_CDB_FWD_EN
    task automatic test_cdb();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.issue_tag = 4'd2;
        tick(); idle();
        bus.rs1_idx = 5'd5;
        bus.B_ALU_valid = 1'b1; bus.B_ALU_rdTag = 4'd2; bus.B_ALU_result = 32'h77;
        bus.B_LSB_valid = 1'b1; bus.B_LSB_rdTag = 4'd2; bus.B_LSB_result = 32'h88;
        #2;
        total++; if (bus.rs1_busy !== 1'b0) begin bad++; $display("FAIL cdb_alu_busy got=%0d exp=0", bus.rs1_busy); end
        total++; if (bus.rs1_val !== 32'h77) begin bad++; $display("FAIL cdb_alu_val got=%h exp=77", bus.rs1_val); end
        bus.B_ALU_valid = 1'b0;
        #1;
        total++; if (bus.rs1_val !== 32'h88) begin bad++; $display("FAIL cdb_lsb_val got=%h exp=88", bus.rs1_val); end
        bus.commit_valid = 1'b1; bus.commit_rd = 5'd5; bus.commit_rdTag = 4'd2; bus.commit_rdVal = 32'h99;
        #1;
        total++; if (bus.rs1_val !== 32'h99) begin bad++; $display("FAIL cdb_commit_prio got=%h exp=99", bus.rs1_val); end
        bus.commit_valid = 1'b0; bus.B_ALU_valid = 1'b1;
        tick(); idle();
        bus.rs1_idx = 5'd5;
        #2;
        total++; if (bus.rs1_busy !== 1'b1) begin bad++; $display("FAIL cdb_state_busy got=%0d exp=1", bus.rs1_busy); end
        total++; if (bus.rs1_tag !== 4'd2) begin bad++; $display("FAIL cdb_state_tag got=%0d exp=2", bus.rs1_tag); end
    endtask
`endif

    task automatic test_random();
        logic                 eb;
        logic [XLEN-1:0]      ev;
        logic [ROB_TAG_W-1:0] et;
        for (int n = 0; n < 400; n++) begin
            rst              = ($urandom_range(0, 99) == 0);
            bus.rdy          = ($urandom_range(0, 7) != 0);
            bus.rollback     = ($urandom_range(0, 15) == 0);
            bus.issue_valid  = 1'($urandom);
            bus.issue_rd     = 5'($urandom_range(0, 7));
            bus.issue_tag    = 4'($urandom);
            bus.commit_valid = 1'($urandom);
            bus.commit_rd    = 5'($urandom_range(0, 7));
            bus.commit_rdTag = ($urandom_range(0, 3) != 0) ? m_tag[bus.commit_rd] : 4'($urandom);
            bus.commit_rdVal = $urandom;
            bus.rs1_idx      = 5'($urandom_range(0, 7));
            bus.rs2_idx      = 5'($urandom_range(0, 7));
`ifdef REGFILE_CDB_FWD_EN
            bus.B_ALU_valid  = 1'($urandom);
            bus.B_ALU_rdTag  = 1'($urandom) ? m_tag[bus.rs1_idx] : 4'($urandom);
            bus.B_ALU_result = $urandom;
            bus.B_LSB_valid  = 1'($urandom);
            bus.B_LSB_rdTag  = 1'($urandom) ? m_tag[bus.rs2_idx] : 4'($urandom);
            bus.B_LSB_result = $urandom;
`endif
            #2;
            model_read(bus.rs1_idx, eb, ev, et);
            total++; if (bus.rs1_busy !== eb) begin bad++; $display("FAIL rnd_rs1_busy n=%0d got=%0d exp=%0d", n, bus.rs1_busy, eb); end
            if (eb) begin
                total++; if (bus.rs1_tag !== et) begin bad++; $display("FAIL rnd_rs1_tag n=%0d got=%0d exp=%0d", n, bus.rs1_tag, et); end
            end else begin
                total++; if (bus.rs1_val !== ev) begin bad++; $display("FAIL rnd_rs1_val n=%0d got=%h exp=%h", n, bus.rs1_val, ev); end
            end
            model_read(bus.rs2_idx, eb, ev, et);
            total++; if (bus.rs2_busy !== eb) begin bad++; $display("FAIL rnd_rs2_busy n=%0d got=%0d exp=%0d", n, bus.rs2_busy, eb); end
            if (eb) begin
                total++; if (bus.rs2_tag !== et) begin bad++; $display("FAIL rnd_rs2_tag n=%0d got=%0d exp=%0d", n, bus.rs2_tag, et); end
            end else begin
                total++; if (bus.rs2_val !== ev) begin bad++; $display("FAIL rnd_rs2_val n=%0d got=%h exp=%h", n, bus.rs2_val, ev); end
            end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_x0();
        test_issue_commit();
        test_stale_commit();
        test_same_cycle();
        test_rollback();
        test_rdy_low();
        test_reset_no_rdy();
`ifdef REGFILE_CDB_FWD_EN
        test_cdb();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
